// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use bubbles, taken-branch flushes,
// memory wait-state freezes, plus saturating stall/flush performance counters.
//
// state | meaning
// RUN   | normal issue; load-use hazards insert one bubble
// FLUSH | multi-cycle branch shadow; IF_ID and ID_EX are being zeroed
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int BR_FLUSH_CYC = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_uses_rs2_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              branch_taken_i,
    input  logic              mem_busy_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              id_ex_write_o,
    output logic              ex_mem_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam logic [3:0] FLUSH_RELOAD = 4'(BR_FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           st_q, st_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic             br_pend_q, br_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             load_use;
    logic             br;

    assign load_use = ex_memread_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
    assign br = branch_taken_i || br_pend_q;

    always_comb begin
        st_d           = st_q;
        fcnt_d         = fcnt_q;
        br_pend_d      = br_pend_q;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        id_ex_write_o  = 1'b1;
        ex_mem_write_o = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;

        if (reset) begin
            st_d      = RUN;
            fcnt_d    = 4'd0;
            br_pend_d = 1'b0;
        end else if (mem_busy_i) begin
            // Freeze everything; a branch resolved now is replayed once memory is ready.
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
            if (branch_taken_i) begin
                br_pend_d = 1'b1;
            end
        end else if (br) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            br_pend_d     = 1'b0;
            if (BR_FLUSH_CYC > 1) begin
                st_d   = FLUSH;
                fcnt_d = FLUSH_RELOAD;
            end else begin
                st_d   = RUN;
            end
        end else if (st_q == FLUSH) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            fcnt_d        = fcnt_q - 4'd1;
            if (fcnt_q == 4'd1) begin
                st_d = RUN;
            end
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_write_o && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (id_ex_flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= RUN;
            fcnt_q      <= 4'd0;
            br_pend_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            st_q        <= st_d;
            fcnt_q      <= fcnt_d;
            br_pend_q   <= br_pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
